// File: rtl/fifo_ram_ctrl.sv
// FIFO controller around an external simple dual-port RAM (registered write, async read).
// Owns the pointers, occupancy and flags and drives every RAM control port.
module fifo_ram_ctrl #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned ADDRESS_WIDTH = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [DATA_WIDTH-1:0]    s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_WIDTH-1:0]    m_data,
  output logic [ADDRESS_WIDTH:0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [ADDRESS_WIDTH-1:0] ram_write_addr,
  output logic [DATA_WIDTH-1:0]    ram_write_data,
  output logic                     ram_write_enable,
  output logic [ADDRESS_WIDTH-1:0] ram_read_addr,
  input  logic [DATA_WIDTH-1:0]    ram_read_data,
  output logic                     ram_read_enable,
  output logic                     ram_chip_select
);

  localparam int unsigned PTR_WIDTH = ADDRESS_WIDTH + 1;

  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic                 push;
  logic                 pop;

  // Flags from the wrap-bit pointer pair; count is the modular difference.
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[ADDRESS_WIDTH-1:0] == rd_ptr[ADDRESS_WIDTH-1:0]) &&
              (wr_ptr[ADDRESS_WIDTH] != rd_ptr[ADDRESS_WIDTH]);
    count   = PTR_WIDTH'(wr_ptr - rd_ptr);
    s_ready = !full && !rst && !flush;
    m_valid = !empty && !rst && !flush;
    push    = s_valid && s_ready;
    pop     = m_valid && m_ready;
  end

  assign ram_write_addr   = wr_ptr[ADDRESS_WIDTH-1:0];
  assign ram_write_data   = s_data;
  assign ram_write_enable = push;
  assign ram_read_addr    = rd_ptr[ADDRESS_WIDTH-1:0];
  assign ram_read_enable  = pop;
  assign m_data           = ram_read_data;
  assign ram_chip_select  = !rst;

  // Reset outranks flush; both return the pointers to zero without touching the RAM.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= PTR_WIDTH'(wr_ptr + PTR_WIDTH'(1));
      if (pop)  rd_ptr <= PTR_WIDTH'(rd_ptr + PTR_WIDTH'(1));
    end
  end

endmodule
